// File: rtl/op_unit_pipe.sv
// op_unit_pipe: two-stage streaming op selector with a running accumulator.
// Stage 1 latches the operand and op code. Stage 2 computes the result and
// holds it until the consumer takes it. The accumulator is committed only on
// the stage-1 -> stage-2 move, so a stalled op can never add twice.
module op_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             acc_ovf,
  output logic             op_err
);

  localparam int H = WIDTH / 2;

  localparam logic [2:0] OP_ADDH   = 3'd0;
  localparam logic [2:0] OP_ODD    = 3'd1;
  localparam logic [2:0] OP_DIV4   = 3'd2;
  localparam logic [2:0] OP_NEG    = 3'd3;
  localparam logic [2:0] OP_ACC    = 3'd4;
  localparam logic [2:0] OP_ACCCLR = 3'd5;
  localparam logic [2:0] OP_PASS   = 3'd6;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [2:0]       r_s1_sel;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_op_err;
  logic [WIDTH-1:0] r_acc;
  logic             r_acc_ovf;

  logic             w_adv2;
  logic             w_in_fire;
  logic             w_move;
  logic [H:0]       w_addh;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_ovf_nxt;

  // Stage 2 can take new data when empty or being drained this cycle.
  assign w_adv2    = !r_out_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_adv2;
  assign w_in_fire = in_valid && in_ready;
  assign w_move    = r_s1_valid && w_adv2;

  assign w_addh = {1'b0, r_s1_a[H-1:0]} + {1'b0, r_s1_a[WIDTH-1:H]};
  assign w_sum  = {1'b0, r_acc} + {1'b0, r_s1_a};

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign op_err    = r_op_err;
  assign acc_ovf   = r_acc_ovf;

  // Result and next accumulator state for the op sitting in stage 1.
  always_comb begin
    w_res     = '0;
    w_err     = 1'b0;
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_acc_ovf;
    case (r_s1_sel)
      OP_ADDH: w_res = WIDTH'(w_addh);
      OP_ODD:  w_res = WIDTH'(r_s1_a[0]);
      OP_DIV4: w_res = r_s1_a >> 2;
      OP_NEG:  w_res = '0 - r_s1_a;
      OP_ACC: begin
        w_acc_nxt = w_sum[WIDTH-1:0];
        w_ovf_nxt = r_acc_ovf | w_sum[WIDTH];
        w_res     = w_sum[WIDTH-1:0];
      end
      OP_ACCCLR: begin
        w_res     = r_acc;
        w_acc_nxt = '0;
        w_ovf_nxt = 1'b0;
      end
      OP_PASS: w_res = r_s1_a;
      default: w_err = 1'b1;
    endcase
  end

  // Stage 1: capture on input transfer, empty when handed to stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_sel   <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= a;
      r_s1_sel   <= sel;
    end else if (w_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: load result on move, hold it while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_op_err    <= 1'b0;
    end else if (w_move) begin
      r_out_valid <= 1'b1;
      r_out       <= w_res;
      r_op_err    <= w_err;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accumulator commits exactly once, when its op enters stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
    end else if (w_move) begin
      r_acc     <= w_acc_nxt;
      r_acc_ovf <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_op_unit_pipe.sv
// Bench for op_unit_pipe (WIDTH=8): directed table, hand-written stall and
// reset sequences, and randomized traffic against an arithmetic model.
module tb_op_unit_pipe;

  typedef struct {
    logic [7:0] a;
    logic [2:0] sel;
    logic [7:0] eo;
    logic       ee;
    logic       eovf;
  } vec_t;

  typedef struct {
    logic [7:0] o;
    logic       e;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       acc_ovf;
  logic       op_err;

  int   total = 0;
  int   bad = 0;
  bit   mon_on = 0;
  int   m_acc = 0;
  bit   m_ovf = 0;
  exp_t exp_q[$];
  vec_t tab[11];

  op_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .acc_ovf(acc_ovf), .op_err(op_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  // Reference behaviour from the op definitions, in plain integer arithmetic.
  task automatic model_step(input logic [7:0] av, input logic [2:0] sv, output exp_t r);
    int ai;
    int s;
    ai = int'(av);
    r.o = 8'h00;
    r.e = 1'b0;
    case (sv)
      3'd0: r.o = 8'((ai % 16) + (ai / 16));
      3'd1: r.o = 8'(ai % 2);
      3'd2: r.o = 8'(ai / 4);
      3'd3: r.o = 8'((256 - ai) % 256);
      3'd4: begin
        s = m_acc + ai;
        if (s > 255) m_ovf = 1;
        m_acc = s % 256;
        r.o = 8'(m_acc);
      end
      3'd5: begin
        r.o = 8'(m_acc);
        m_acc = 0;
        m_ovf = 0;
      end
      3'd6: r.o = av;
      default: r.e = 1'b1;
    endcase
    r.ovf = m_ovf;
  endtask

  // Output monitor: every presented result must match the head of the queue.
  always @(negedge clk) begin
    if (mon_on && rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        chk("out", {24'b0, out}, {24'b0, exp_q[0].o});
        chk("op_err", {31'b0, op_err}, {31'b0, exp_q[0].e});
        chk("acc_ovf", {31'b0, acc_ovf}, {31'b0, exp_q[0].ovf});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] av, input logic [2:0] sv,
                      input bit use_tab, input exp_t te, input bit rnd);
    exp_t m;
    bit   done;
    done = 0;
    in_valid = 1'b1;
    a = av;
    sel = sv;
    for (int k = 0; k < 100 && !done; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        model_step(av, sv, m);
        exp_q.push_back(use_tab ? te : m);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", {31'b0, done}, 32'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("drain", {31'b0, ok}, 32'd1);
  endtask

  initial begin
    exp_t e0;
    exp_t dummy;
    logic [7:0] bp_v[3];
    int idx;

    tab[0]  = '{8'hA7, 3'd0, 8'h11, 1'b0, 1'b0};
    tab[1]  = '{8'hA7, 3'd1, 8'h01, 1'b0, 1'b0};
    tab[2]  = '{8'hA7, 3'd2, 8'h29, 1'b0, 1'b0};
    tab[3]  = '{8'hA7, 3'd3, 8'h59, 1'b0, 1'b0};
    tab[4]  = '{8'hF0, 3'd4, 8'hF0, 1'b0, 1'b0};
    tab[5]  = '{8'h20, 3'd4, 8'h10, 1'b0, 1'b1};
    tab[6]  = '{8'h00, 3'd5, 8'h10, 1'b0, 1'b0};
    tab[7]  = '{8'h05, 3'd4, 8'h05, 1'b0, 1'b0};
    tab[8]  = '{8'hFF, 3'd7, 8'h00, 1'b1, 1'b0};
    tab[9]  = '{8'h01, 3'd4, 8'h06, 1'b0, 1'b0};
    tab[10] = '{8'h3C, 3'd6, 8'h3C, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = 8'h00;
    sel = 3'd0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out", {24'b0, out}, 32'd0);
    chk("rst_op_err", {31'b0, op_err}, 32'd0);
    chk("rst_acc_ovf", {31'b0, acc_ovf}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Latency: accepted at edge k, visible after edge k+1.
    in_valid = 1'b1;
    a = 8'hA7;
    sel = 3'd0;
    @(negedge clk);
    chk("lat_in_ready", {31'b0, in_ready}, 32'd1);
    model_step(8'hA7, 3'd0, dummy);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_out", {24'b0, out}, 32'h11);
    @(posedge clk);
    #1;
    mon_on = 1;

    // Directed table, back to back.
    for (int i = 0; i < 11; i++) begin
      e0.o = tab[i].eo;
      e0.e = tab[i].ee;
      e0.ovf = tab[i].eovf;
      send(tab[i].a, tab[i].sel, 1, e0, 0);
    end
    drain();

    // Back-pressure: three offered, two accepted, then released in order.
    bp_v[0] = 8'h12;
    bp_v[1] = 8'h34;
    bp_v[2] = 8'h56;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 3);
      a = bp_v[idx < 3 ? idx : 2];
      sel = 3'd6;
      @(negedge clk);
      if (in_valid && in_ready) begin
        model_step(a, sel, dummy);
        exp_q.push_back(dummy);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", idx, 32'd2);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_out_hold", {24'b0, out}, 32'h12);
    out_ready = 1'b1;
    send(bp_v[2], 3'd6, 0, e0, 0);
    drain();

    // Stalled ACC commits once.
    send(8'h00, 3'd5, 0, e0, 0);
    drain();
    out_ready = 1'b0;
    send(8'h05, 3'd4, 0, e0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_acc_mid", {24'b0, dut.r_acc}, 32'h05);
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    drain();
    chk("stall_acc_after", {24'b0, dut.r_acc}, 32'h05);

    // Randomized traffic with random back-pressure.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 0, e0, 1);
    end
    drain();

    // Reset with both stages full, acc=0x33, acc_ovf=1.
    send(8'h00, 3'd5, 0, e0, 0);
    send(8'hF0, 3'd4, 0, e0, 0);
    e0.o = 8'h33;
    e0.e = 1'b0;
    e0.ovf = 1'b1;
    send(8'h43, 3'd4, 1, e0, 0);
    drain();
    out_ready = 1'b0;
    send(8'hAA, 3'd6, 0, e0, 0);
    send(8'h55, 3'd6, 0, e0, 0);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("pre_rst_acc", {24'b0, dut.r_acc}, 32'h33);
    mon_on = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out", {24'b0, out}, 32'd0);
    chk("mid_rst_acc_ovf", {31'b0, acc_ovf}, 32'd0);
    chk("mid_rst_acc", {24'b0, dut.r_acc}, 32'd0);
    exp_q.delete();
    m_acc = 0;
    m_ovf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    mon_on = 1;
    repeat (3) begin
      @(negedge clk);
      chk("no_spurious_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    e0.o = 8'h01;
    e0.e = 1'b0;
    e0.ovf = 1'b0;
    send(8'h01, 3'd4, 1, e0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/op_unit_pipe.md
Name: op_unit_pipe

Overview:
- Parametrised, pipelined successor of the 4-bit combinational op selector (half-add, odd/even, divide-by-4, two's complement).
- Extends it to WIDTH bits, a 3-bit op code, and a running accumulator with a sticky carry flag.
- Adds valid/ready handshakes on input and output, so it sits in streaming datapaths between a producer and a consumer that may back-pressure.

Parameters:
- WIDTH, 8, operand/result width; must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  stage 1 can accept this cycle
- a  input  WIDTH  operand
- sel  input  3  op code
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  result
- acc_ovf  output  1  sticky accumulator carry-out flag
- op_err  output  1  result came from reserved op code (qualified by out_valid)

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0, out=0, op_err=0, acc=0, acc_ovf=0. in_ready is 1 once reset is released.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out, op_err stable while out_valid && !out_ready.
- Pipeline, two register stages, no bubbles when unstalled:
  - Stage 1 captures a and sel.
  - Stage 2 computes the result and registers it into out/op_err.
  - adv2 = !out_valid || out_ready. in_ready = !s1_valid || adv2 (combinational).
  - Stage 1 moves into stage 2 when s1_valid && adv2.
  - Latency: 2 cycles from accepted input to out_valid with out_ready held high. Throughput: 1 per cycle.
- Op codes; H = WIDTH/2; results are zero-extended to WIDTH:
  - 0 ADDH: a[H-1:0] + a[WIDTH-1:H]. The H+1-bit sum is zero-extended; it never overflows.
  - 1 ODD: out = {0..., a[0]}, i.e. 1 if odd, 0 if even.
  - 2 DIV4: a >> 2 (logical).
  - 3 NEG: (~a + 1) mod 2^WIDTH.
  - 4 ACC:
    - acc <= acc + a mod 2^WIDTH; out = the new acc value.
    - Carry-out sets acc_ovf; the flag stays set.
  - 5 ACCCLR: out = old acc; acc <= 0; acc_ovf <= 0.
  - 6 PASS: out = a.
  - 7 reserved: out = 0, op_err = 1. acc is untouched.
- acc and acc_ovf update only in the cycle the op moves from stage 1 to stage 2. A stalled op never updates acc twice.
- Back-to-back ACC ops chain correctly: each one sees the acc value written by its predecessor.
- Full pipeline (s1_valid && out_valid && !out_ready): in_ready=0. Inputs are ignored and nothing is lost.
- On a stall release, out_ready=1 with s1 full: out takes the s1 result and s1 may accept a new input in the same cycle.
- rst_n asserted mid-operation:
  - All in-flight data is discarded and acc/acc_ovf clear immediately (asynchronously).
  - No spurious out_valid after release.

Test Plan:
- WIDTH=8, out_ready=1. Send a=8'hA7 with sel=0,1,2,3 on consecutive cycles. Outputs are 8'h11, 8'h01, 8'h29, 8'h59, one per cycle, with the first on cycle 2 after acceptance.
- Send ACC with 8'hF0 then ACC with 8'h20. Outputs are 8'hF0 then 8'h10; acc_ovf rises with the second result and stays 1. Then send ACCCLR: out=8'h10 and acc_ovf=0.
- Back-pressure: out_ready=0 with 3 valid inputs offered. Exactly 2 are accepted, in_ready=0 afterwards, and out holds the first result. Raise out_ready: all 3 results emerge in order, unchanged.
- Stall during ACC: send ACC with 8'h05 while out_ready=0 for 4 cycles. After release, out=8'h05 once and the internal acc equals 8'h05, with no duplicate add.
- sel=7 with a=8'hFF: out=8'h00 and op_err=1. A following ACC with 8'h01 returns the pre-error acc + 1.
- Assert rst_n=0 with both stages full and acc=8'h33. Outputs clear immediately. After release, in_ready=1, and ACC with 8'h01 returns 8'h01.
